// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter/sequencer in front of the memory block.
// Waits out the memory's init sweep, then runs one pulsed access at a time with a ready timeout.
module mem_arbiter #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int INIT_CYCLES  = 40,
  parameter int TIMEOUT      = 15,
  parameter int CNT_SIZE     = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    c0_req,
  input  logic                    c0_we,
  input  logic [ADDRESS_SIZE-1:0] c0_addr,
  input  logic [WORD_SIZE-1:0]    c0_wdata,
  output logic                    c0_ack,
  output logic                    c0_err,
  output logic [WORD_SIZE-1:0]    c0_rdata,
  input  logic                    c1_req,
  input  logic                    c1_we,
  input  logic [ADDRESS_SIZE-1:0] c1_addr,
  input  logic [WORD_SIZE-1:0]    c1_wdata,
  output logic                    c1_ack,
  output logic                    c1_err,
  output logic [WORD_SIZE-1:0]    c1_rdata,
  output logic                    mem_w_en,
  output logic                    mem_r_en,
  output logic [ADDRESS_SIZE-1:0] mem_w_addr,
  output logic [ADDRESS_SIZE-1:0] mem_r_addr,
  output logic [WORD_SIZE-1:0]    mem_w_data,
  input  logic [WORD_SIZE-1:0]    mem_r_data,
  input  logic                    mem_r_rdy,
  input  logic                    mem_w_rdy,
  output logic                    init_done
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT_RDY,
    S_DONE
  } state_t;

  state_t                         r_state, w_state_next;
  logic [CNT_SIZE-1:0]            r_cnt, w_cnt_next;
  logic                           r_last, w_last_next;
  logic                           r_win, w_win_next;
  logic                           r_we, w_we_next;
  logic                           r_mem_w_en, w_mem_w_en_next;
  logic                           r_mem_r_en, w_mem_r_en_next;
  logic [ADDRESS_SIZE-1:0]        r_mem_w_addr, w_mem_w_addr_next;
  logic [ADDRESS_SIZE-1:0]        r_mem_r_addr, w_mem_r_addr_next;
  logic [WORD_SIZE-1:0]           r_mem_w_data, w_mem_w_data_next;
  logic [1:0]                     r_ack, w_ack_next;
  logic [1:0]                     r_err, w_err_next;
  logic [1:0][WORD_SIZE-1:0]      r_rdata, w_rdata_next;
  logic                           r_init_done, w_init_done_next;

  // Winner selection: on contention the client that was not served last wins.
  logic                    w_sel;
  logic                    w_sel_we;
  logic [ADDRESS_SIZE-1:0] w_sel_addr;
  logic [WORD_SIZE-1:0]    w_sel_wdata;
  logic                    w_rdy;

  assign w_sel       = (c0_req & c1_req) ? ~r_last : c1_req;
  assign w_sel_we    = w_sel ? c1_we    : c0_we;
  assign w_sel_addr  = w_sel ? c1_addr  : c0_addr;
  assign w_sel_wdata = w_sel ? c1_wdata : c0_wdata;
  assign w_rdy       = r_we ? mem_w_rdy : mem_r_rdy;

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_last_next       = r_last;
    w_win_next        = r_win;
    w_we_next         = r_we;
    w_mem_w_en_next   = 1'b0;
    w_mem_r_en_next   = 1'b0;
    w_mem_w_addr_next = r_mem_w_addr;
    w_mem_r_addr_next = r_mem_r_addr;
    w_mem_w_data_next = r_mem_w_data;
    w_ack_next        = 2'b00;
    w_err_next        = 2'b00;
    w_rdata_next      = r_rdata;
    w_init_done_next  = r_init_done;

    case (r_state)
      S_INIT: begin
        if (r_cnt == '0) begin
          w_state_next     = S_IDLE;
          w_init_done_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_SIZE'(1);
        end
      end
      S_IDLE: begin
        // Outputs are registered, so the enable is set here to appear during ISSUE.
        if (c0_req || c1_req) begin
          w_win_next        = w_sel;
          w_we_next         = w_sel_we;
          w_mem_w_en_next   = w_sel_we;
          w_mem_r_en_next   = ~w_sel_we;
          w_mem_w_data_next = w_sel_wdata;
          if (w_sel_we) begin
            w_mem_w_addr_next = w_sel_addr;
          end else begin
            w_mem_r_addr_next = w_sel_addr;
          end
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_SETTLE;
      end
      S_SETTLE: begin
        w_cnt_next   = CNT_SIZE'(TIMEOUT - 1);
        w_state_next = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (w_rdy) begin
          w_ack_next[r_win] = 1'b1;
          if (!r_we) begin
            w_rdata_next[r_win] = mem_r_data;
          end
          w_state_next = S_DONE;
        end else if (r_cnt == '0) begin
          w_ack_next[r_win] = 1'b1;
          w_err_next[r_win] = 1'b1;
          w_state_next      = S_DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_SIZE'(1);
        end
      end
      S_DONE: begin
        w_last_next  = r_win;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_cnt        <= CNT_SIZE'(INIT_CYCLES - 1);
      r_last       <= 1'b1;
      r_win        <= 1'b0;
      r_we         <= 1'b0;
      r_mem_w_en   <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_mem_w_addr <= '0;
      r_mem_r_addr <= '0;
      r_mem_w_data <= '0;
      r_ack        <= 2'b00;
      r_err        <= 2'b00;
      r_rdata      <= '0;
      r_init_done  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_last       <= w_last_next;
      r_win        <= w_win_next;
      r_we         <= w_we_next;
      r_mem_w_en   <= w_mem_w_en_next;
      r_mem_r_en   <= w_mem_r_en_next;
      r_mem_w_addr <= w_mem_w_addr_next;
      r_mem_r_addr <= w_mem_r_addr_next;
      r_mem_w_data <= w_mem_w_data_next;
      r_ack        <= w_ack_next;
      r_err        <= w_err_next;
      r_rdata      <= w_rdata_next;
      r_init_done  <= w_init_done_next;
    end
  end

  assign c0_ack     = r_ack[0];
  assign c1_ack     = r_ack[1];
  assign c0_err     = r_err[0];
  assign c1_err     = r_err[1];
  assign c0_rdata   = r_rdata[0];
  assign c1_rdata   = r_rdata[1];
  assign mem_w_en   = r_mem_w_en;
  assign mem_r_en   = r_mem_r_en;
  assign mem_w_addr = r_mem_w_addr;
  assign mem_r_addr = r_mem_r_addr;
  assign mem_w_data = r_mem_w_data;
  assign init_done  = r_init_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory (ready two cycles after enable).
module tb_mem_arbiter;
  localparam int WS = 8;
  localparam int AS = 4;
  localparam int IC = 40;
  localparam int TO = 15;
  localparam int CS = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          c0_req = 1'b0, c0_we = 1'b0;
  logic [AS-1:0] c0_addr = '0;
  logic [WS-1:0] c0_wdata = '0;
  logic          c0_ack, c0_err;
  logic [WS-1:0] c0_rdata;
  logic          c1_req = 1'b0, c1_we = 1'b0;
  logic [AS-1:0] c1_addr = '0;
  logic [WS-1:0] c1_wdata = '0;
  logic          c1_ack, c1_err;
  logic [WS-1:0] c1_rdata;
  logic          mem_w_en, mem_r_en;
  logic [AS-1:0] mem_w_addr, mem_r_addr;
  logic [WS-1:0] mem_w_data, mem_r_data;
  logic          mem_r_rdy, mem_w_rdy;
  logic          init_done;
  logic          tie_low = 1'b0;

  always #5 clock = ~clock;

  mem_arbiter #(
    .WORD_SIZE(WS), .ADDRESS_SIZE(AS), .INIT_CYCLES(IC), .TIMEOUT(TO), .CNT_SIZE(CS)
  ) dut (
    .clock(clock), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_err(c0_err), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_err(c1_err), .c1_rdata(c1_rdata),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
    .mem_r_rdy(mem_r_rdy), .mem_w_rdy(mem_w_rdy),
    .init_done(init_done)
  );

  // Memory model: contents reset to 0; ready rises two edges after the enable and stays high.
  logic [WS-1:0] mem_arr [16];
  logic          m_w_rdy, m_r_rdy, m_w_pend, m_r_pend;
  logic [WS-1:0] m_r_data;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
      m_w_rdy <= 1'b0; m_r_rdy <= 1'b0; m_w_pend <= 1'b0; m_r_pend <= 1'b0;
      m_r_data <= '0;
    end else begin
      if (mem_w_en) begin
        mem_arr[mem_w_addr] <= mem_w_data;
        m_w_rdy <= 1'b0; m_w_pend <= 1'b1;
      end else if (m_w_pend) begin
        m_w_rdy <= 1'b1; m_w_pend <= 1'b0;
      end
      if (mem_r_en) begin
        m_r_data <= mem_arr[mem_r_addr];
        m_r_rdy <= 1'b0; m_r_pend <= 1'b1;
      end else if (m_r_pend) begin
        m_r_rdy <= 1'b1; m_r_pend <= 1'b0;
      end
    end
  end

  assign mem_w_rdy  = m_w_rdy & ~tie_low;
  assign mem_r_rdy  = m_r_rdy & ~tie_low;
  assign mem_r_data = m_r_data;

  // Interface monitor, sampling the cycle that just ended.
  int            w_pulses = 0, r_pulses = 0, early = 0, both = 0, ack_cnt = 0;
  logic [AS-1:0] lw_addr = '0, lr_addr = '0;
  logic [WS-1:0] lw_data = '0;

  always @(posedge clock) begin
    if (mem_w_en) begin w_pulses++; lw_addr = mem_w_addr; lw_data = mem_w_data; end
    if (mem_r_en) begin r_pulses++; lr_addr = mem_r_addr; end
    if ((mem_w_en || mem_r_en) && !init_done) early++;
    if (mem_w_en && mem_r_en) both++;
    if (c0_ack || c1_ack) ack_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic wait_ack(input int c, input int maxc, output int lat, output logic err,
                          output logic [WS-1:0] rd);
    lat = -1; err = 1'b0; rd = '0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clock);
      if ((c == 0 && c0_ack) || (c == 1 && c1_ack)) begin
        lat = i;
        err = (c == 0) ? c0_err : c1_err;
        rd  = (c == 0) ? c0_rdata : c1_rdata;
        if (c == 0) c0_req = 1'b0; else c1_req = 1'b0;
        break;
      end
    end
  endtask

  // Issues one request from an IDLE negedge and returns to the following IDLE negedge.
  task automatic xfer(input int c, input logic we, input logic [AS-1:0] a, input logic [WS-1:0] d,
                      output int lat, output logic err, output logic [WS-1:0] rd);
    if (c == 0) begin c0_we = we; c0_addr = a; c0_wdata = d; c0_req = 1'b1; end
    else        begin c1_we = we; c1_addr = a; c1_wdata = d; c1_req = 1'b1; end
    wait_ack(c, 40, lat, err, rd);
    @(negedge clock);
  endtask

  initial begin
    int            lat, cnt, k, cyc, p0, a0;
    logic          err, r0, r1;
    logic [WS-1:0] rd;
    int            order [6];
    int            at [6];

    repeat (3) @(negedge clock);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_acks", {c0_ack, c1_ack, c0_err, c1_err}, 0);
    check_eq("rst_mem_en", {mem_w_en, mem_r_en}, 0);
    check_eq("rst_mem_w_data", mem_w_data, 0);
    check_eq("rst_c0_rdata", c0_rdata, 0);

    // c0 write requested throughout INIT; served once init_done rises.
    c0_we = 1'b1; c0_addr = 4'd3; c0_wdata = 8'hA5; c0_req = 1'b1;
    reset = 1'b0;
    cnt = 0;
    while (!init_done && cnt < 100) begin @(negedge clock); cnt++; end
    check_eq("init_len", cnt, IC);
    check_eq("no_w_before_init", w_pulses, 0);
    wait_ack(0, 40, lat, err, rd);
    check_eq("wr_lat", lat, 4);
    check_eq("wr_err", err, 0);
    check_eq("wr_pulses", w_pulses, 1);
    check_eq("wr_addr", lw_addr, 3);
    check_eq("wr_data", lw_data, 8'hA5);
    @(negedge clock);

    p0 = r_pulses;
    xfer(1, 1'b0, 4'd3, 8'h00, lat, err, rd);
    check_eq("rd_lat", lat, 4);
    check_eq("rd_err", err, 0);
    check_eq("rd_data", rd, 8'hA5);
    check_eq("rd_pulses", r_pulses - p0, 1);
    check_eq("rd_addr", lr_addr, 3);

    // Six contention grants: both clients keep requesting, re-raising in the IDLE after their ack.
    c0_we = 1'b1; c0_addr = 4'd5; c0_wdata = 8'h5C;
    c1_we = 1'b1; c1_addr = 4'd6; c1_wdata = 8'h6D;
    c0_req = 1'b1; c1_req = 1'b1;
    k = 0; cyc = 0; r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 100 && k < 6; i++) begin
      @(negedge clock);
      cyc++;
      if (r0) begin c0_req = 1'b1; r0 = 1'b0; end
      if (r1) begin c1_req = 1'b1; r1 = 1'b0; end
      if (c0_ack) begin order[k] = 0; at[k] = cyc; k++; c0_req = 1'b0; r0 = 1'b1; end
      if (c1_ack) begin order[k] = 1; at[k] = cyc; k++; c1_req = 1'b0; r1 = 1'b1; end
      if (k == 6) begin c0_req = 1'b0; c1_req = 1'b0; end
    end
    check_eq("rr_grants", k, 6);
    if (k == 6) begin
      for (int j = 0; j < 6; j++) check_eq($sformatf("rr_order%0d", j), order[j], j % 2);
      for (int j = 1; j < 6; j++) check_eq($sformatf("rr_space%0d", j), at[j] - at[j-1], 5);
    end
    @(negedge clock);

    xfer(0, 1'b0, 4'd6, 8'h00, lat, err, rd);
    check_eq("rd6_data", rd, 8'h6D);
    xfer(0, 1'b0, 4'd9, 8'h00, lat, err, rd);
    check_eq("rd_unwritten", rd, 8'h00);
    xfer(0, 1'b0, 4'd5, 8'h00, lat, err, rd);
    check_eq("rd5_data", rd, 8'h5C);

    // Ready held low: timeout after TO cycles in WAIT_RDY, rdata untouched.
    tie_low = 1'b1;
    xfer(0, 1'b0, 4'd6, 8'h00, lat, err, rd);
    check_eq("to_lat", lat, 3 + TO);
    check_eq("to_err", err, 1);
    check_eq("to_rdata_held", rd, 8'h5C);
    tie_low = 1'b0;
    xfer(1, 1'b1, 4'd7, 8'h77, lat, err, rd);
    check_eq("after_to_lat", lat, 4);
    check_eq("after_to_err", err, 0);
    check_eq("c1_rdata_held_on_wr", rd, 8'hA5);

    // Reset while stuck in WAIT_RDY.
    tie_low = 1'b1;
    c0_we = 1'b0; c0_addr = 4'd7; c0_req = 1'b1;
    repeat (5) @(negedge clock);
    a0 = ack_cnt;
    reset = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_init_done", init_done, 0);
    check_eq("mid_rst_rdata", c0_rdata, 0);
    c0_we = 1'b1; c0_addr = 4'd4; c0_wdata = 8'h3C;
    tie_low = 1'b0;
    p0 = w_pulses;
    reset = 1'b0;
    cnt = 0;
    while (!init_done && cnt < 100) begin @(negedge clock); cnt++; end
    check_eq("reinit_len", cnt, IC);
    check_eq("reinit_no_ack", ack_cnt - a0, 0);
    check_eq("reinit_no_w", w_pulses - p0, 0);
    wait_ack(0, 40, lat, err, rd);
    check_eq("post_rst_lat", lat, 4);
    @(negedge clock);
    xfer(1, 1'b0, 4'd4, 8'h00, lat, err, rd);
    check_eq("post_rst_rd", rd, 8'h3C);

    check_eq("never_both_en", both, 0);
    check_eq("never_en_in_init", early, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
